// File: rtl/prog_loader.sv
// prog_loader: streams a CHIP-8 program image from a byte link into program RAM.
// A 2-byte big-endian length header precedes the payload. Each payload byte
// is written to consecutive addresses starting at BASE_ADDR.
// Optional checksum trailer: define PROG_LOADER_CHKSUM_EN.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready is a registered decode of the receiving states and never looks at
// in_valid, so the byte source may hold or drop in_valid freely.
//
// dbg_state exposes the FSM state encoding for debug and checker binding.

module prog_loader #(
    parameter logic [11:0] BASE_ADDR = 12'h200,
    parameter int          MEM_SIZE  = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  dbg_state
);

    // Largest payload that fits between BASE_ADDR and the top of RAM, so the
    // write address can never wrap past MEM_SIZE-1.
    localparam logic [15:0] MAX_LEN = 16'(MEM_SIZE - int'(BASE_ADDR));

`ifdef PROG_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5,
        S_CSUM   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;
`endif

    state_t      state_q;
    logic        in_ready_q;
    logic        mem_we_q;
    logic [11:0] mem_addr_q;
    logic [7:0]  mem_din_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [15:0] len_q;
    logic [15:0] cnt_q;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0]  sum_q;
`endif

    logic        accept;
    logic [15:0] len_full;
    logic        last_byte;

    assign accept    = in_valid && in_ready_q;
    // Full length as it will be once the low header byte lands this cycle.
    assign len_full  = {len_q[15:8], in_data};
    // In DATA, len_q >= 1, so len_q - 1 never underflows there.
    assign last_byte = (cnt_q == (len_q - 16'd1));

    // Loader FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 12'd0;
            mem_din_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            len_q      <= 16'd0;
            cnt_q      <= 16'd0;
`ifdef PROG_LOADER_CHKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            // The write strobe is a one-cycle pulse per accepted payload byte.
            mem_we_q <= 1'b0;

            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q    <= S_LEN_HI;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        len_q      <= 16'd0;
                        cnt_q      <= 16'd0;
`ifdef PROG_LOADER_CHKSUM_EN
                        sum_q      <= 8'd0;
`endif
                    end
                end

                S_LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= in_data;
                        state_q     <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= in_data;
                        cnt_q      <= 16'd0;
                        if (len_full > MAX_LEN) begin
                            // Image would run off the top of RAM: reject it
                            // before anything is written.
                            state_q    <= S_ERR;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else if (len_full == 16'd0) begin
`ifdef PROG_LOADER_CHKSUM_EN
                            // Empty image still carries a checksum byte.
                            state_q <= S_CSUM;
`else
                            state_q    <= S_DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
`endif
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= BASE_ADDR + cnt_q[11:0];
                        mem_din_q  <= in_data;
                        cnt_q      <= cnt_q + 16'd1;
`ifdef PROG_LOADER_CHKSUM_EN
                        sum_q      <= sum_q + in_data;
                        if (last_byte) begin
                            state_q <= S_CSUM;
                        end
`else
                        if (last_byte) begin
                            // done/busy change on the same edge as the final write.
                            state_q    <= S_DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end
`endif
                    end
                end

`ifdef PROG_LOADER_CHKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (in_data == sum_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. A transaction-level model tracks the
// load (bytes received, header length, running sum) and predicts every
// output each cycle; expected RAM writes go through an expected queue.
module tb_prog_loader;

  localparam logic [11:0] BASE    = 12'h200;
  localparam int          MAX_LEN = 4096 - 512;
`ifdef PROG_LOADER_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_din;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [19:0] exp_q[$];
  logic [7:0]  ram [0:4095];
  logic [7:0]  tx_q[$];
  bit          chk_en = 1'b0;
  bit          tog = 1'b0;

  // transaction-level model of the loader
  bit          m_busy;
  bit          m_done;
  bit          m_err;
  bit          m_we;
  logic [11:0] m_addr;
  logic [7:0]  m_din;
  int          m_got;
  int          m_len;
  logic [7:0]  m_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_finish(input bit ok);
    m_busy = 1'b0;
    m_done = ok;
    m_err  = !ok;
  endtask

  // Advance the model by one clock edge using the inputs that edge will see.
  task automatic model_step();
    logic [7:0] b;
    int         idx;
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_we = 0;
      m_addr = '0; m_din = '0; m_got = 0; m_len = 0; m_sum = '0;
      exp_q.delete();
      return;
    end
    m_we = 1'b0;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_done = 0; m_err = 0; m_got = 0; m_len = 0; m_sum = '0;
      end
    end else if (in_valid) begin
      b = in_data;
      if (m_got == 0) begin
        m_len = int'(b) * 256;
      end else if (m_got == 1) begin
        m_len = m_len + int'(b);
        if (m_len > MAX_LEN) model_finish(1'b0);
        else if (m_len == 0 && !CHK) model_finish(1'b1);
      end else if (m_got - 2 < m_len) begin
        idx    = m_got - 2;
        m_we   = 1'b1;
        m_addr = 12'(int'(BASE) + idx);
        m_din  = b;
        m_sum  = m_sum + b;
        exp_q.push_back({m_addr, b});
        if (idx == m_len - 1 && !CHK) model_finish(1'b1);
      end else begin
        model_finish(b == m_sum);
      end
      m_got++;
    end
  endtask

  // Compare DUT outputs to the model away from the active edge, then advance.
  always @(negedge clk) begin
    logic [19:0] w;
    if (chk_en) begin
      chk("in_ready", in_ready, m_busy);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_din", mem_din, m_din);
      if (mem_we === 1'b1) begin
        ram[mem_addr] = mem_din;
        if (exp_q.size() == 0) begin
          chk("write_expected", exp_q.size(), 1);
        end else begin
          w = exp_q.pop_front();
          chk("write_addr", mem_addr, w[19:8]);
          chk("write_data", mem_din, w[7:0]);
        end
      end
    end
    model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Send tx_q; mode 0 = continuous valid, 1 = toggle, 2 = random gaps + stray starts.
  task automatic send_tx(input int mode);
    bit acc;
    bit v;
    int waits;
    for (int i = 0; i < tx_q.size(); i++) begin
      waits = 0;
      forever begin
        case (mode)
          0: v = 1'b1;
          1: begin v = tog; tog = !tog; end
          default: begin
            v = ($urandom_range(0, 2) != 0);
            start = ($urandom_range(0, 3) == 0);
          end
        endcase
        in_valid = v;
        in_data  = v ? tx_q[i] : 8'($urandom);
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (acc) break;
        waits++;
        if (waits > 200) begin
          n_cmp++; n_err++;
          $display("FAIL handshake_timeout: byte %0d never accepted", i);
          in_valid = 1'b0; start = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  function automatic logic [7:0] tx_sum();
    logic [7:0] s = '0;
    for (int i = 2; i < tx_q.size(); i++) s = s + tx_q[i];
    return s;
  endfunction

  task automatic load(input int len, input int mode);
    tx_q.delete();
    tx_q.push_back(8'(len >> 8));
    tx_q.push_back(8'(len));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len;
    int mode;
    logic [7:0] s;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    idle(3);
    chk_en = 1'b1;
    start = 1'b1;  // rst wins over start
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_ready", in_ready, 0);
    chk("reset_we", mem_we, 0);
    chk("reset_addr", mem_addr, 0);
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    idle(2);

    // basic 3-byte image, continuous and toggled valid
    for (int pass = 0; pass < 2; pass++) begin
      ram[12'h200] = '0; ram[12'h201] = '0; ram[12'h202] = '0;
      tx_q = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
      if (CHK) tx_q.push_back(8'h31);
      do_start();
      send_tx(pass);
      idle(2);
      @(negedge clk);
      chk("basic_ram200", ram[12'h200], 8'hAA);
      chk("basic_ram201", ram[12'h201], 8'hBB);
      chk("basic_ram202", ram[12'h202], 8'hCC);
      chk("basic_done", done, 1);
      chk("basic_ready_low", in_ready, 0);
    end

    // largest legal image fills up to 0xFFF
    ram[12'hFFF] = '0;
    tx_q = '{8'h0E, 8'h00};
    for (int i = 0; i < MAX_LEN; i++) tx_q.push_back(8'h5A);
    if (CHK) tx_q.push_back(8'h00);
    do_start();
    send_tx(0);
    idle(2);
    @(negedge clk);
    chk("max_ram_fff", ram[12'hFFF], 8'h5A);
    chk("max_done", done, 1);

    // one byte too long is rejected
    tx_q = '{8'h0E, 8'h01};
    do_start();
    send_tx(0);
    idle(2);
    @(negedge clk);
    chk("over_error", error, 1);
    chk("over_busy", busy, 0);
    chk("over_done", done, 0);

    // empty image
    tx_q = '{8'h00, 8'h00};
    if (CHK) tx_q.push_back(8'h00);
    do_start();
    send_tx(0);
    @(negedge clk);
    chk("empty_done", done, 1);
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    chk("restart_done_clr", done, 0);
    chk("restart_busy", busy, 1);
    @(posedge clk); #1;
    send_tx(0);
    idle(2);

    // reset part way through the payload
    tx_q = '{8'h00, 8'h05, 8'h11, 8'h22};
    do_start();
    send_tx(0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_we", mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_din", mem_din, 0);
    @(posedge clk); #1;
    tx_q = '{8'h00, 8'h01, 8'h77};
    if (CHK) tx_q.push_back(8'h77);
    do_start();
    send_tx(0);
    idle(2);
    @(negedge clk);
    chk("after_rst_ram200", ram[12'h200], 8'h77);
    chk("after_rst_done", done, 1);

`ifdef PROG_LOADER_CHKSUM_EN
    for (int pass = 0; pass < 2; pass++) begin
      ram[12'h200] = '0; ram[12'h201] = '0;
      tx_q = '{8'h00, 8'h02, 8'h10, 8'h20};
      tx_q.push_back(pass == 0 ? 8'h30 : 8'h31);
      do_start();
      send_tx(0);
      idle(2);
      @(negedge clk);
      chk("csum_done", done, (pass == 0));
      chk("csum_error", error, (pass == 1));
      chk("csum_ram200", ram[12'h200], 8'h10);
      chk("csum_ram201", ram[12'h201], 8'h20);
    end
`endif

    // randomized loads
    for (int t = 0; t < 16; t++) begin
      len  = (t == 5) ? 16'hFFFF : $urandom_range(0, 24);
      mode = $urandom_range(0, 2);
      tx_q.delete();
      tx_q.push_back(8'(len >> 8));
      tx_q.push_back(8'(len));
      if (len <= MAX_LEN) begin
        for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
        s = tx_sum();
        if (CHK) tx_q.push_back(($urandom_range(0, 3) == 0) ? s + 8'd1 : s);
      end
      do_start();
      send_tx(mode);
      idle($urandom_range(1, 4));
    end

    idle(2);
    @(negedge clk);
    chk("writes_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Memory-write counterpart to the program ROM read port: streams a CHIP-8 program image from a byte source (e.g. a UART receiver) into the 4 KiB program RAM.
- Sits between the host byte link and the RAM write port.
- Accepts a 2-byte big-endian length header, then writes each payload byte to consecutive addresses from BASE_ADDR.
- Holds off the CPU via busy until the image is loaded.

Parameters:
- BASE_ADDR, 12'h200, first RAM address written (CHIP-8 program start).
- MEM_SIZE, 4096, RAM depth in bytes; the last legal address is MEM_SIZE-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  begin a new load; honoured only when not busy
- in_valid  input  1  in_data holds a byte
- in_data  input  8  incoming byte
- in_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  RAM write strobe, one cycle per byte
- mem_addr  output  12  RAM write address
- mem_din  output  8  RAM write data
- busy  output  1  load in progress
- done  output  1  last load completed OK (level)
- error  output  1  last load rejected (level)

Behaviour:
- Reset: state IDLE. in_ready, mem_we, busy, done and error are all 0. mem_addr and mem_din are 0. Length and count registers are 0.
- Handshake: a byte is accepted on a rising edge where in_valid && in_ready. in_ready is a registered state decode, high only in LEN_HI, LEN_LO and DATA (and CSUM, see feature). It does not depend on in_valid.
- State IDLE/DONE/ERR, start=1: go to LEN_HI. Clear done and error, set busy.
- State IDLE/DONE/ERR, start=0: hold.
- start while busy: ignored.
- LEN_HI: accept byte, len[15:8] <= byte, go to LEN_LO.
- LEN_LO: accept byte, len[7:0] <= byte. Then:
  - if len > MEM_SIZE-BASE_ADDR (3584 at defaults): go to ERR, error=1, busy=0.
  - else if len == 0: go to DONE, done=1, busy=0.
  - else: cnt <= 0, go to DATA.
- DATA: on each accepted byte:
  - next cycle: mem_we=1, mem_addr=BASE_ADDR+cnt, mem_din=byte.
  - cnt increments.
  - When cnt reaches len-1 at acceptance, go to DONE. done and busy update on the same edge that issues the final mem_we.
- Write latency: exactly 1 cycle from accept edge to the mem_we high cycle.
- mem_we is never high two cycles for the same byte.
- Back-to-back valid bytes give one write per cycle (full throughput).
- Address range: the header check means mem_addr never wraps or exceeds MEM_SIZE-1.
- Gaps: in_valid may drop for any number of cycles in any receiving state. The state holds and there is no timeout.
- Reset mid-load: returns to IDLE on that edge. mem_we=0 from that edge. RAM contents already written are left as-is. done and error are cleared.
- Simultaneous rst and start: rst wins.
- mem_addr and mem_din hold their last values while mem_we=0.

Optional Feature:
- Macro PROG_LOADER_CHKSUM_EN.
- With it defined:
  - After the last payload byte, go to CSUM instead of DONE, with busy held.
  - Accept one checksum byte. It equals the 8-bit modulo-256 sum of all payload bytes.
  - Match: done=1. Mismatch: error=1. busy=0 in both cases.
  - Payload bytes are still written to RAM regardless of the checksum result.
  - len==0: still expects one checksum byte; 0x00 passes.
- Without it: no CSUM state and no sum register. DONE follows the last payload byte directly.

Test Plan:
- Reset, then start, then stream 00 03 AA BB CC with continuous valid.
  - Writes (0x200,AA), (0x201,BB), (0x202,CC) on consecutive cycles, each 1 cycle after accept.
  - done=1, busy=0; in_ready=0 afterwards.
- Same stream with in_valid toggled every other cycle: identical writes, one per accepted byte, no duplicate mem_we.
- Header 0E 00 then 3584 bytes of 0x5A: final write at 0xFFF, done=1. Header 0E 01: no mem_we, error=1, busy=0.
- Header 00 00: no writes, done=1 the cycle after LEN_LO accept. A following start clears done and raises busy.
- Assert rst after 2 of 5 payload bytes: mem_we=0 from reset edge, all outputs at reset values. A new load of 00 01 77 then writes (0x200,77).
- (PROG_LOADER_CHKSUM_EN) Stream 00 02 10 20 30: done=1. Stream 00 02 10 20 31: error=1. In both, RAM 0x200=10 and 0x201=20.
